// File: rtl/store_pkg.sv
// Shared definitions for the store packer: store op encodings, byte-enable
// patterns and the packed write entry carried through the FIFO.
package store_pkg;

  typedef enum logic [1:0] {
    OP_SW   = 2'd0,
    OP_SH   = 2'd1,
    OP_SB   = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE    = 4'b0001;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

endpackage

// File: rtl/store_packer_if.sv
// Request, memory-write and error signals of the store packer; the slave
// modport is the packer itself, the master modport is the surrounding core/memory.
interface store_packer_if #(parameter int DEPTH = 2);
  import store_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  op_e                      req_op;
  logic [31:0]              req_addr;
  logic [31:0]              req_data;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_be;
  logic                     err_valid;
  logic [31:0]              err_addr;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  req_valid, req_op, req_addr, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
           err_valid, err_addr, count
  );

  modport master (
    output req_valid, req_op, req_addr, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be,
           err_valid, err_addr, count
  );

endinterface

// File: rtl/sync_fifo.sv
// Power-of-two deep FIFO of packed store entries; head entry is read
// combinationally from storage, occupancy is a registered count.
module sync_fifo
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 wr_data,
  input  logic                   pop,
  output entry_t                 rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          storage [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; a zero count already marks every slot empty,
  // and leaving it out keeps the array mappable onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= wr_data;
  end

  assign rd_data = storage[rd_ptr];

endmodule

// File: rtl/store_packer.sv
// Packs sw/sh/sb stores into lane-replicated word writes with byte enables,
// rejects misaligned/reserved requests and buffers good ones in sync_fifo.
module store_packer
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  store_packer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  entry_t          pack_entry;
  entry_t          head;
  logic            bad;
  logic            accept;
  logic            pop;
  logic [CW-1:0]   occ;

  // Ready depends only on the registered occupancy, never on a same-cycle pop.
  assign bus.req_ready = (occ < CW'(DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.mem_valid && bus.mem_ready;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pack_entry      = '0;
    bad             = 1'b0;
    pack_entry.addr = {bus.req_addr[31:2], 2'b00};
    case (bus.req_op)
      OP_SW: begin
        pack_entry.wdata = bus.req_data;
        pack_entry.be    = BE_WORD;
        bad              = (bus.req_addr[1:0] != 2'b00);
      end
      OP_SH: begin
        pack_entry.wdata = {2{bus.req_data[15:0]}};
        pack_entry.be    = bus.req_addr[1] ? BE_HALF_HI : BE_HALF_LO;
        bad              = bus.req_addr[0];
      end
      OP_SB: begin
        pack_entry.wdata = {4{bus.req_data[7:0]}};
        pack_entry.be    = BE_BYTE << bus.req_addr[1:0];
      end
      default: bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.err_valid <= 1'b0;
      bus.err_addr  <= '0;
    end else begin
      bus.err_valid <= accept && bad;
      if (accept && bad) bus.err_addr <= bus.req_addr;
    end
  end

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept && !bad),
    .wr_data (pack_entry),
    .pop     (pop),
    .rd_data (head),
    .count   (occ)
  );

  assign bus.count     = occ;
  assign bus.mem_valid = (occ != '0);
  assign bus.mem_addr  = head.addr;
  assign bus.mem_wdata = head.wdata;
  assign bus.mem_be    = bus.mem_valid ? head.be : 4'b0000;

endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer: a queue-based model of accepted writes is
// compared against the DUT every falling edge, plus literal spot checks.
module tb_store_packer;
  import store_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_packer_if #(.DEPTH(DEPTH)) bus ();

  store_packer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules, expressed with plain arithmetic on the byte address.
  function automatic bit legal(input op_e op, input logic [31:0] a);
    case (op)
      OP_SW:   return (a % 4) == 0;
      OP_SH:   return (a % 2) == 0;
      OP_SB:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic entry_t expect_entry(input op_e op, input logic [31:0] a, input logic [31:0] d);
    entry_t e;
    e.addr = a - (a % 4);
    case (op)
      OP_SW: begin
        e.wdata = d;
        e.be    = 4'd15;
      end
      OP_SH: begin
        e.wdata = (d & 32'h0000_FFFF) * 32'h0001_0001;
        e.be    = ((a % 4) >= 2) ? 4'd12 : 4'd3;
      end
      default: begin
        e.wdata = (d & 32'h0000_00FF) * 32'h0101_0101;
        e.be    = 4'(1 << (a % 4));
      end
    endcase
    return e;
  endfunction

  entry_t      exp_q[$];
  bit          exp_err = 1'b0;
  logic [31:0] exp_err_addr = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      exp_err      <= 1'b0;
      exp_err_addr <= '0;
    end else begin
      automatic bit acc = bus.req_valid && (exp_q.size() < DEPTH);
      automatic bit pp  = (exp_q.size() != 0) && bus.mem_ready;
      exp_err <= 1'b0;
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        if (legal(bus.req_op, bus.req_addr))
          exp_q.push_back(expect_entry(bus.req_op, bus.req_addr, bus.req_data));
        else begin
          exp_err      <= 1'b1;
          exp_err_addr <= bus.req_addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_count", 32'(bus.count), 32'(exp_q.size()));
    check("model_req_ready", 32'(bus.req_ready), 32'(exp_q.size() < DEPTH));
    check("model_mem_valid", 32'(bus.mem_valid), 32'(exp_q.size() != 0));
    check("model_err_valid", 32'(bus.err_valid), 32'(exp_err));
    check("model_err_addr", bus.err_addr, exp_err_addr);
    if (exp_q.size() != 0) begin
      check("model_mem_addr", bus.mem_addr, exp_q[0].addr);
      check("model_mem_wdata", bus.mem_wdata, exp_q[0].wdata);
      check("model_mem_be", 32'(bus.mem_be), 32'(exp_q[0].be));
    end else begin
      check("model_mem_be_idle", 32'(bus.mem_be), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request for exactly one clock edge.
  task automatic push_one(input op_e op, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_data  = d;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic set_req(input op_e op, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
    check({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'd1);
    check({tag, "_mem_addr"}, bus.mem_addr, a);
    check({tag, "_mem_wdata"}, bus.mem_wdata, w);
    check({tag, "_mem_be"}, 32'(bus.mem_be), 32'(be));
  endtask

  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t mix[8];

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_SW;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.mem_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check("rst_err_valid", 32'(bus.err_valid), 32'd0);
    check("rst_err_addr", bus.err_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single stores, each visible one cycle after acceptance.
    bus.mem_ready = 1'b1;
    push_one(OP_SW, 32'h0000_1004, 32'h1234_5678);
    @(negedge clk);
    check_head("sw", 32'h0000_1004, 32'h1234_5678, 4'b1111);
    push_one(OP_SH, 32'h0000_2006, 32'hFFFF_82CA);
    @(negedge clk);
    check_head("sh", 32'h0000_2004, 32'h82CA_82CA, 4'b1100);
    check("sh_count_pushpop", 32'(bus.count), 32'd1);
    push_one(OP_SB, 32'h0000_3003, 32'h0000_011C);
    @(negedge clk);
    check_head("sb", 32'h0000_3000, 32'h1C1C_1C1C, 4'b1000);
    tick();
    @(negedge clk);
    check("drain_count", 32'(bus.count), 32'd0);

    // Rejected requests.
    push_one(OP_SH, 32'h0000_0001, 32'h0000_BEEF);
    @(negedge clk);
    check("err_pulse", 32'(bus.err_valid), 32'd1);
    check("err_addr", bus.err_addr, 32'h0000_0001);
    check("err_count", 32'(bus.count), 32'd0);
    check("err_mem_valid", 32'(bus.mem_valid), 32'd0);
    @(negedge clk);
    check("err_one_cycle", 32'(bus.err_valid), 32'd0);
    check("err_addr_hold", bus.err_addr, 32'h0000_0001);
    push_one(OP_SW, 32'h0000_1002, 32'h1111_1111);
    @(negedge clk);
    push_one(OP_RSVD, 32'h0000_0010, 32'h2222_2222);
    @(negedge clk);
    check("err_rsvd_addr", bus.err_addr, 32'h0000_0010);
    check("err_rsvd_count", 32'(bus.count), 32'd0);

    // Back-pressure: three offers into a two-deep FIFO.
    bus.mem_ready = 1'b0;
    set_req(OP_SB, 32'h0000_4001, 32'h0000_00AB);
    tick();
    set_req(OP_SH, 32'h0000_4006, 32'h0000_1234);
    tick();
    set_req(OP_SW, 32'h0000_4008, 32'hCAFE_F00D);
    tick();
    @(negedge clk);
    check("full_req_ready", 32'(bus.req_ready), 32'd0);
    check("full_count", 32'(bus.count), 32'd2);
    check_head("full_a", 32'h0000_4000, 32'hABAB_ABAB, 4'b0010);
    tick();
    @(negedge clk);
    check_head("stall_a", 32'h0000_4000, 32'hABAB_ABAB, 4'b0010);
    bus.mem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("pop_full_count", 32'(bus.count), 32'd1);
    check_head("drain_b", 32'h0000_4004, 32'h1234_1234, 4'b1100);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("drain_c_count", 32'(bus.count), 32'd1);
    check_head("drain_c", 32'h0000_4008, 32'hCAFE_F00D, 4'b1111);
    tick();
    @(negedge clk);
    check("drained_count", 32'(bus.count), 32'd0);
    check("drained_mem_valid", 32'(bus.mem_valid), 32'd0);

    // Reset while two entries are pending.
    bus.mem_ready = 1'b0;
    push_one(OP_SW, 32'h0000_6000, 32'h6666_6666);
    push_one(OP_SW, 32'h0000_6004, 32'h7777_7777);
    @(negedge clk);
    check("prerst_count", 32'(bus.count), 32'd2);
    #1 reset = 1'b0;
    #1;
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("midrst_mem_be", 32'(bus.mem_be), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_write", 32'(bus.mem_valid), 32'd0);
    end

    // Mixed lanes with intermittent memory back-pressure.
    mix[0] = '{OP_SB, 32'h0000_5000, 32'h0000_0011};
    mix[1] = '{OP_SB, 32'h0000_5001, 32'h0000_0022};
    mix[2] = '{OP_SB, 32'h0000_5002, 32'h0000_0033};
    mix[3] = '{OP_SB, 32'h0000_5003, 32'h0000_0044};
    mix[4] = '{OP_SH, 32'h0000_5004, 32'hAAAA_5566};
    mix[5] = '{OP_SH, 32'h0000_5006, 32'hBBBB_7788};
    mix[6] = '{OP_SW, 32'h0000_5008, 32'h99AA_BBCC};
    mix[7] = '{OP_SH, 32'h0000_500B, 32'h0000_DDEE};
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = (i % 3) != 2;
      push_one(mix[i].op, mix[i].addr, mix[i].data);
    end
    bus.mem_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("final_count", 32'(bus.count), 32'd0);
    check("final_err_addr", bus.err_addr, 32'h0000_500B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
